// File: rtl/hci_core_mux_static_ctrl.sv
// Select controller for an HCI static mux: tracks in-flight transactions on the
// mux output and only moves the select once the active channel has drained.
//
// state  | meaning
// ACTIVE | select stable, req passes while below MAX_OUTSTANDING
// DRAIN  | req gated, waiting for every outstanding response to return
// SWITCH | new select applied, ack pulsed, one settle cycle with req gated
module hci_core_mux_static_ctrl #(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned RESET_SEL       = 0,
  localparam int unsigned SW             = $clog2(NB_CHAN-1)+1,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          switch_req_i,
  input  logic [SW-1:0] switch_sel_i,
  output logic          switch_ack_o,
  output logic [SW-1:0] sel_o,
  output logic          req_gate_o,
  input  logic          mon_req_i,
  input  logic          mon_gnt_i,
  input  logic          mon_r_valid_i,
  input  logic          mon_r_ready_i,
  output logic [CW-1:0] outstanding_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] SEL_RST = SW'(RESET_SEL);

  state_t        state;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] target_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          ack_q;
  logic          inc;
  logic          dec;
  logic          sel_valid;

  assign inc       = mon_req_i & mon_gnt_i;
  assign dec       = mon_r_valid_i & mon_r_ready_i;
  assign sel_valid = 32'(switch_sel_i) < NB_CHAN;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ACTIVE;
      sel_q    <= SEL_RST;
      target_q <= SEL_RST;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else if (clear_i) begin
      state    <= ACTIVE;
      sel_q    <= SEL_RST;
      target_q <= SEL_RST;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;

      // Overflow/underflow saturate the count and flag a protocol error.
      case ({inc, dec})
        2'b10: begin
          if (cnt_q == CNT_MAX) err_q <= 1'b1;
          else                  cnt_q <= cnt_q + CW'(1);
        end
        2'b01: begin
          if (cnt_q == '0) err_q <= 1'b1;
          else             cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase

      case (state)
        ACTIVE: begin
          // A request still held during the error-ack cycle must not re-trigger.
          if (switch_req_i && !ack_q) begin
            if (sel_valid) begin
              target_q <= switch_sel_i;
              state    <= DRAIN;
            end else begin
              err_q <= 1'b1;
              ack_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == '0 && !dec) begin
            sel_q <= target_q;
            ack_q <= 1'b1;
            state <= SWITCH;
          end
        end
        SWITCH:  state <= ACTIVE;
        default: state <= ACTIVE;
      endcase
    end
  end

  assign switch_ack_o  = ack_q;
  assign sel_o         = sel_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;
  assign busy_o        = (state != ACTIVE);
  assign req_gate_o    = (state == ACTIVE) && (cnt_q < CNT_MAX);

endmodule

// File: tb/tb_hci_core_mux_static_ctrl.sv
// Bench for hci_core_mux_static_ctrl: directed scenarios followed by random
// traffic compared cycle by cycle against a behavioural model.
module tb_hci_core_mux_static_ctrl;

  localparam int NB   = 4;
  localparam int MAXO = 4;
  localparam int RSEL = 1;
  localparam int SW   = $clog2(NB-1)+1;
  localparam int CW   = $clog2(MAXO+1);

  localparam int PH_RUN    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          switch_req_i = 1'b0;
  logic [SW-1:0] switch_sel_i = '0;
  logic          switch_ack_o;
  logic [SW-1:0] sel_o;
  logic          req_gate_o;
  logic          mon_req_i = 1'b0;
  logic          mon_gnt_i = 1'b0;
  logic          mon_r_valid_i = 1'b0;
  logic          mon_r_ready_i = 1'b0;
  logic [CW-1:0] outstanding_o;
  logic          busy_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  int m_cnt, m_sel, m_target, m_phase;
  bit m_err, m_ack;

  hci_core_mux_static_ctrl #(
    .NB_CHAN(NB), .MAX_OUTSTANDING(MAXO), .RESET_SEL(RSEL)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .switch_req_i(switch_req_i), .switch_sel_i(switch_sel_i),
    .switch_ack_o(switch_ack_o), .sel_o(sel_o), .req_gate_o(req_gate_o),
    .mon_req_i(mon_req_i), .mon_gnt_i(mon_gnt_i),
    .mon_r_valid_i(mon_r_valid_i), .mon_r_ready_i(mon_r_ready_i),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void m_reset();
    m_cnt = 0; m_sel = RSEL; m_target = RSEL; m_phase = PH_RUN;
    m_err = 1'b0; m_ack = 1'b0;
  endfunction

  function automatic bit m_gate();
    return (m_phase == PH_RUN) && (m_cnt < MAXO);
  endfunction

  // One clock of the reference behaviour, using the inputs present at the edge.
  function automatic void model_step();
    bit inc, dec, ack_was;
    int cnt_was, ph_was;
    inc = mon_req_i & mon_gnt_i;
    dec = mon_r_valid_i & mon_r_ready_i;
    if (clear_i) begin
      m_reset();
      return;
    end
    cnt_was = m_cnt; ph_was = m_phase; ack_was = m_ack;
    m_ack = 1'b0;
    if (inc && !dec) begin
      if (m_cnt == MAXO) m_err = 1'b1; else m_cnt = m_cnt + 1;
    end else if (dec && !inc) begin
      if (m_cnt == 0) m_err = 1'b1; else m_cnt = m_cnt - 1;
    end
    if (ph_was == PH_RUN) begin
      if (switch_req_i && !ack_was) begin
        if (int'(switch_sel_i) < NB) begin
          m_target = int'(switch_sel_i);
          m_phase  = PH_WAIT;
        end else begin
          m_err = 1'b1;
          m_ack = 1'b1;
        end
      end
    end else if (ph_was == PH_WAIT) begin
      if (cnt_was == 0 && !dec) begin
        m_sel   = m_target;
        m_ack   = 1'b1;
        m_phase = PH_SETTLE;
      end
    end else begin
      m_phase = PH_RUN;
    end
  endfunction

  task automatic step();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    if ({sel_o, req_gate_o, busy_o, switch_ack_o, err_o, outstanding_o} !==
        {SW'(RSEL), 1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b",
               {sel_o, req_gate_o, busy_o, switch_ack_o, err_o, outstanding_o},
               {SW'(RSEL), 1'b1, 1'b0, 1'b0, 1'b0, CW'(0)});
    end
    total++;
    rst_ni = 1'b1;
    m_reset();
  endtask

  task automatic test_idle_switch();
    switch_sel_i = SW'(2); switch_req_i = 1'b1;
    step();
    if ({sel_o, req_gate_o, busy_o, switch_ack_o} !== {SW'(1), 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL idle_drain got=%b exp=%b", {sel_o, req_gate_o, busy_o, switch_ack_o}, {SW'(1), 3'b010});
    end
    total++;
    step();
    if ({sel_o, req_gate_o, busy_o, switch_ack_o} !== {SW'(2), 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL idle_ack got=%b exp=%b", {sel_o, req_gate_o, busy_o, switch_ack_o}, {SW'(2), 3'b011});
    end
    total++;
    switch_req_i = 1'b0;
    step();
    if ({sel_o, req_gate_o, busy_o, switch_ack_o} !== {SW'(2), 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL idle_back got=%b exp=%b", {sel_o, req_gate_o, busy_o, switch_ack_o}, {SW'(2), 3'b100});
    end
    total++;
  endtask

  task automatic test_drain();
    mon_req_i = 1'b1; mon_gnt_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (outstanding_o !== CW'(i)) begin
        bad++; $display("FAIL drain_fill got=%0d exp=%0d", outstanding_o, i);
      end
      total++;
    end
    mon_req_i = 1'b0; mon_gnt_i = 1'b0;
    switch_sel_i = SW'(3); switch_req_i = 1'b1;
    step();
    for (int r = 0; r < 3; r++) begin
      repeat (3) begin
        if ({sel_o, req_gate_o, switch_ack_o, outstanding_o} !== {SW'(2), 1'b0, 1'b0, CW'(3-r)}) begin
          bad++; $display("FAIL drain_wait got=%b exp=%b", {sel_o, req_gate_o, switch_ack_o, outstanding_o}, {SW'(2), 2'b00, CW'(3-r)});
        end
        total++;
        step();
      end
      mon_r_valid_i = 1'b1; mon_r_ready_i = 1'b1;
      step();
      mon_r_valid_i = 1'b0; mon_r_ready_i = 1'b0;
      if ({sel_o, req_gate_o, switch_ack_o, outstanding_o} !== {SW'(2), 1'b0, 1'b0, CW'(2-r)}) begin
        bad++; $display("FAIL drain_resp got=%b exp=%b", {sel_o, req_gate_o, switch_ack_o, outstanding_o}, {SW'(2), 2'b00, CW'(2-r)});
      end
      total++;
    end
    step();
    if ({sel_o, req_gate_o, busy_o, switch_ack_o} !== {SW'(3), 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL drain_ack got=%b exp=%b", {sel_o, req_gate_o, busy_o, switch_ack_o}, {SW'(3), 3'b011});
    end
    total++;
    switch_req_i = 1'b0;
    step();
    if ({req_gate_o, busy_o, switch_ack_o} !== 3'b100) begin
      bad++; $display("FAIL drain_done got=%b exp=100", {req_gate_o, busy_o, switch_ack_o});
    end
    total++;
  endtask

  task automatic test_saturation();
    mon_req_i = 1'b1; mon_gnt_i = 1'b1;
    repeat (MAXO) step();
    mon_req_i = 1'b0; mon_gnt_i = 1'b0;
    if ({req_gate_o, outstanding_o} !== {1'b0, CW'(MAXO)}) begin
      bad++; $display("FAIL sat_full got=%b exp=%b", {req_gate_o, outstanding_o}, {1'b0, CW'(MAXO)});
    end
    total++;
    mon_r_valid_i = 1'b1; mon_r_ready_i = 1'b1;
    step();
    mon_r_valid_i = 1'b0; mon_r_ready_i = 1'b0;
    if ({req_gate_o, outstanding_o} !== {1'b1, CW'(MAXO-1)}) begin
      bad++; $display("FAIL sat_release got=%b exp=%b", {req_gate_o, outstanding_o}, {1'b1, CW'(MAXO-1)});
    end
    total++;
    mon_r_valid_i = 1'b1; mon_r_ready_i = 1'b1;
    repeat (MAXO-1) step();
    mon_r_valid_i = 1'b0; mon_r_ready_i = 1'b0;
    if ({err_o, outstanding_o} !== {1'b0, CW'(0)}) begin
      bad++; $display("FAIL sat_empty got=%b exp=%b", {err_o, outstanding_o}, {1'b0, CW'(0)});
    end
    total++;
  endtask

  task automatic test_simultaneous();
    mon_req_i = 1'b1; mon_gnt_i = 1'b1;
    step();
    mon_r_valid_i = 1'b1; mon_r_ready_i = 1'b1;
    step();
    if ({err_o, outstanding_o} !== {1'b0, CW'(1)}) begin
      bad++; $display("FAIL simul_hold got=%b exp=%b", {err_o, outstanding_o}, {1'b0, CW'(1)});
    end
    total++;
    mon_req_i = 1'b0; mon_gnt_i = 1'b0;
    step();
    step();
    mon_r_valid_i = 1'b0; mon_r_ready_i = 1'b0;
    if ({err_o, outstanding_o} !== {1'b1, CW'(0)}) begin
      bad++; $display("FAIL underflow got=%b exp=%b", {err_o, outstanding_o}, {1'b1, CW'(0)});
    end
    total++;
    repeat (3) step();
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b exp=1", err_o);
    end
    total++;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    if ({sel_o, err_o, outstanding_o} !== {SW'(RSEL), 1'b0, CW'(0)}) begin
      bad++; $display("FAIL err_clear got=%b exp=%b", {sel_o, err_o, outstanding_o}, {SW'(RSEL), 1'b0, CW'(0)});
    end
    total++;
  endtask

  task automatic test_clear_drain();
    mon_req_i = 1'b1; mon_gnt_i = 1'b1;
    step();
    mon_req_i = 1'b0; mon_gnt_i = 1'b0;
    switch_sel_i = SW'(0); switch_req_i = 1'b1;
    step();
    step();
    if ({busy_o, switch_ack_o} !== 2'b10) begin
      bad++; $display("FAIL clr_pre got=%b exp=10", {busy_o, switch_ack_o});
    end
    total++;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    if ({sel_o, req_gate_o, busy_o, switch_ack_o, outstanding_o} !== {SW'(RSEL), 3'b100, CW'(0)}) begin
      bad++; $display("FAIL clr_abort got=%b exp=%b", {sel_o, req_gate_o, busy_o, switch_ack_o, outstanding_o}, {SW'(RSEL), 3'b100, CW'(0)});
    end
    total++;
    step();
    if ({busy_o, switch_ack_o} !== 2'b10) begin
      bad++; $display("FAIL clr_redrain got=%b exp=10", {busy_o, switch_ack_o});
    end
    total++;
    step();
    if ({sel_o, switch_ack_o} !== {SW'(0), 1'b1}) begin
      bad++; $display("FAIL clr_ack got=%b exp=%b", {sel_o, switch_ack_o}, {SW'(0), 1'b1});
    end
    total++;
    switch_req_i = 1'b0;
    step();
  endtask

  task automatic test_invalid_sel();
    switch_sel_i = SW'(5); switch_req_i = 1'b1;
    step();
    if ({sel_o, switch_ack_o, err_o, busy_o} !== {SW'(0), 3'b110}) begin
      bad++; $display("FAIL bad_sel got=%b exp=%b", {sel_o, switch_ack_o, err_o, busy_o}, {SW'(0), 3'b110});
    end
    total++;
    switch_req_i = 1'b0;
    step();
    if ({sel_o, switch_ack_o, err_o} !== {SW'(0), 2'b01}) begin
      bad++; $display("FAIL bad_sel_after got=%b exp=%b", {sel_o, switch_ack_o, err_o}, {SW'(0), 2'b01});
    end
    total++;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic test_random();
    logic [CW+SW+3:0] got, exp;
    for (int i = 0; i < 3000; i++) begin
      exp = {CW'(m_cnt), SW'(m_sel), m_gate(), (m_phase != PH_RUN), m_ack, m_err};
      got = {outstanding_o, sel_o, req_gate_o, busy_o, switch_ack_o, err_o};
      if (got !== exp) begin
        bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got, exp);
      end
      total++;
      clear_i = ($urandom_range(0, 99) == 0);
      if (switch_req_i && m_ack) begin
        switch_req_i = 1'b0;
      end else if (!switch_req_i && $urandom_range(0, 11) == 0) begin
        switch_req_i = 1'b1;
        switch_sel_i = SW'($urandom_range(0, 5));
      end
      mon_req_i     = ($urandom_range(0, 49) == 0) ? 1'b1 : (m_gate() & 1'($urandom_range(0, 1)));
      mon_gnt_i     = 1'($urandom_range(0, 1));
      mon_r_valid_i = (m_cnt > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      mon_r_ready_i = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_idle_switch();
    test_drain();
    test_saturation();
    test_simultaneous();
    test_clear_drain();
    test_invalid_sel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
